// File: rtl/vram_arbiter.sv
// Shares a single-port video RAM between VGA scan-out reads and queued CPU pixel writes.
// Scan-out gets the RAM in its read slots; CPU writes drain from a small FIFO in every other cycle.
module vram_arbiter #(
    parameter int SCALE_LOG2 = 1,
    parameter int ADDR_W     = 17,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          vga_clk,
    input  logic                          clrn,
    input  logic [8:0]                    row_addr,
    input  logic [9:0]                    col_addr,
    input  logic                          rdn,
    output logic [11:0]                   d_out,
    input  logic                          cpu_valid,
    output logic                          cpu_ready,
    input  logic [ADDR_W-1:0]             cpu_addr,
    input  logic [11:0]                   cpu_data,
    input  logic                          err_clr,
    output logic                          addr_err,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [ADDR_W-1:0]             ram_addr,
    output logic [11:0]                   ram_wdata,
    output logic                          ram_we,
    input  logic [11:0]                   ram_rdata
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int LINE_W  = 640 >> SCALE_LOG2;
    localparam int PIX_MAX = (640 * 480) >> (2 * SCALE_LOG2);

    logic [ADDR_W-1:0]      row_s;
    logic [ADDR_W-1:0]      col_s;
    logic [ADDR_W-1:0]      pix_addr;
    logic                   read_slot;
    logic                   fifo_empty;
    logic                   in_range;
    logic                   accept;
    logic                   push;
    logic                   pop;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [11:0]            hold;
    logic [ADDR_W+11:0]     mem [FIFO_DEPTH];
    logic [ADDR_W+11:0]     head;

    assign row_s    = ADDR_W'(row_addr >> SCALE_LOG2);
    assign col_s    = ADDR_W'(col_addr >> SCALE_LOG2);
    assign pix_addr = row_s * ADDR_W'(LINE_W) + col_s;

    // With pixel replication the odd columns repeat the previous pixel, so they are free slots.
    assign read_slot  = !rdn && ((SCALE_LOG2 == 0) || !col_addr[0]);
    assign fifo_empty = (fifo_count == '0);
    assign in_range   = (cpu_addr < ADDR_W'(PIX_MAX));
    assign cpu_ready  = clrn && (fifo_count != CNT_W'(FIFO_DEPTH));
    assign accept     = cpu_valid && cpu_ready;
    assign push       = accept && in_range;
    assign pop        = !read_slot && !fifo_empty;
    assign head       = mem[rd_ptr];

    assign ram_we    = clrn && pop;
    assign ram_addr  = pop ? head[ADDR_W+11:12] : pix_addr;
    assign ram_wdata = head[11:0];
    assign d_out     = read_slot ? ram_rdata : hold;

    always_ff @(posedge vga_clk) begin
        if (push) begin
            mem[wr_ptr] <= {cpu_addr, cpu_data};
        end
    end

    // Pending writes are deliberately discarded on reset; the RAM contents themselves are untouched.
    always_ff @(posedge vga_clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            addr_err   <= 1'b0;
            hold       <= '0;
        end else begin
            if (read_slot) begin
                hold <= ram_rdata;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
            if (err_clr) begin
                addr_err <= 1'b0;
            end else if (accept && !in_range) begin
                addr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: address mapping vectors, a write scoreboard and
// directed sequences for FIFO full, line scan, address errors and reset mid-drain.
module tb_vram_arbiter;

    localparam int S     = 1;
    localparam int AW    = 17;
    localparam int D     = 4;
    localparam int CW    = 3;
    localparam int MAXA  = 76800;

    logic           vga_clk = 1'b0;
    logic           clrn = 1'b0;
    logic [8:0]     row_addr = '0;
    logic [9:0]     col_addr = '0;
    logic           rdn = 1'b1;
    logic [11:0]    d_out;
    logic           cpu_valid = 1'b0;
    logic           cpu_ready;
    logic [AW-1:0]  cpu_addr = '0;
    logic [11:0]    cpu_data = '0;
    logic           err_clr = 1'b0;
    logic           addr_err;
    logic [CW-1:0]  fifo_count;
    logic [AW-1:0]  ram_addr;
    logic [11:0]    ram_wdata;
    logic           ram_we;
    logic [11:0]    ram_rdata;

    logic [11:0]    ram [0:(1<<AW)-1];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [11:0]   data;
    } wr_t;

    typedef struct {
        logic [8:0]    row;
        logic [9:0]    col;
        logic          rdn;
        logic [AW-1:0] exp_addr;
        logic [11:0]   exp_dout;
    } vec_t;

    wr_t    exp_q[$];
    wr_t    exp_e;
    vec_t   vecs[8];
    int     tests = 0;
    int     fails = 0;
    int     line_n;
    int     bad;
    logic   acc;

    vram_arbiter #(.SCALE_LOG2(S), .ADDR_W(AW), .FIFO_DEPTH(D)) dut (
        .vga_clk(vga_clk), .clrn(clrn), .row_addr(row_addr), .col_addr(col_addr),
        .rdn(rdn), .d_out(d_out), .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
        .cpu_addr(cpu_addr), .cpu_data(cpu_data), .err_clr(err_clr), .addr_err(addr_err),
        .fifo_count(fifo_count), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    always #5 vga_clk = ~vga_clk;

    assign ram_rdata = ram[ram_addr];
    always @(posedge vga_clk) if (ram_we) ram[ram_addr] <= ram_wdata;

    // Every RAM write must match the oldest accepted in-range CPU write and avoid read slots.
    always @(negedge vga_clk) begin
        if (!clrn) begin
            exp_q.delete();
        end else begin
            if (ram_we === 1'b1) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL sb_write: unexpected write addr=%0d data=%h", ram_addr, ram_wdata);
                end else begin
                    exp_e = exp_q.pop_front();
                    if (exp_e.addr !== ram_addr || exp_e.data !== ram_wdata || (!rdn && !col_addr[0])) begin
                        fails++;
                        $display("[TB] FAIL sb_write: got addr=%0d data=%h rdn=%b col=%0d, wanted addr=%0d data=%h outside read slot",
                                 ram_addr, ram_wdata, rdn, col_addr, exp_e.addr, exp_e.data);
                    end
                end
            end
            if (cpu_valid && cpu_ready && cpu_addr < AW'(MAXA))
                exp_q.push_back({cpu_addr, cpu_data});
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [8:0] r, input logic [9:0] c, input logic n);
        @(posedge vga_clk); #1;
        row_addr = r;
        col_addr = c;
        rdn      = n;
    endtask

    task automatic pushWrite(input logic [AW-1:0] a, input logic [11:0] d);
        @(posedge vga_clk); #1;
        cpu_valid = 1'b1;
        cpu_addr  = a;
        cpu_data  = d;
        @(posedge vga_clk); #1;
        cpu_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge vga_clk);
            if (fifo_count == '0) break;
        end
        checkOutput(name, 32'(fifo_count), 32'd0);
    endtask

    initial begin
        vecs[0] = '{9'd0,   10'd0,   1'b0, AW'(0),     12'hF00};
        vecs[1] = '{9'd0,   10'd1,   1'b0, AW'(0),     12'hF00};
        vecs[2] = '{9'd2,   10'd0,   1'b0, AW'(320),   12'h0A5};
        vecs[3] = '{9'd3,   10'd1,   1'b0, AW'(320),   12'h0A5};
        vecs[4] = '{9'd479, 10'd639, 1'b0, AW'(76799), 12'h0A5};
        vecs[5] = '{9'd479, 10'd638, 1'b0, AW'(76799), 12'h123};
        vecs[6] = '{9'd2,   10'd0,   1'b1, AW'(320),   12'h123};
        vecs[7] = '{9'd1,   10'd3,   1'b0, AW'(1),     12'h123};

        // Reset holds off CPU requests.
        cpu_valid = 1'b1;
        cpu_addr  = AW'(7);
        @(negedge vga_clk);
        checkOutput("rst_ready", 32'(cpu_ready), 32'd0);
        checkOutput("rst_we", 32'(ram_we), 32'd0);
        checkOutput("rst_count", 32'(fifo_count), 32'd0);
        checkOutput("rst_err", 32'(addr_err), 32'd0);
        @(posedge vga_clk); #1;
        cpu_valid = 1'b0;
        clrn      = 1'b1;
        @(negedge vga_clk);
        checkOutput("rel_ready", 32'(cpu_ready), 32'd1);

        // Preload RAM through the arbiter itself.
        pushWrite(AW'(0), 12'hF00);
        pushWrite(AW'(320), 12'h0A5);
        pushWrite(AW'(76799), 12'h123);
        waitDrain("preload_drain");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].row, vecs[i].col, vecs[i].rdn);
            @(negedge vga_clk);
            checkOutput($sformatf("vec%0d_addr", i), 32'(ram_addr), 32'(vecs[i].exp_addr));
            checkOutput($sformatf("vec%0d_we", i), 32'(ram_we), 32'd0);
            checkOutput($sformatf("vec%0d_dout", i), 32'(d_out), 32'(vecs[i].exp_dout));
        end

        // FIFO fills while scan-out owns the RAM, then drains in order once it is free.
        applyStimulus(9'd0, 10'd0, 1'b0);
        cpu_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cpu_addr = AW'(i);
            cpu_data = 12'(i);
            @(posedge vga_clk); #1;
        end
        cpu_addr = AW'(5);
        cpu_data = 12'd5;
        @(negedge vga_clk);
        checkOutput("full_ready", 32'(cpu_ready), 32'd0);
        checkOutput("full_count", 32'(fifo_count), 32'd4);
        checkOutput("full_we", 32'(ram_we), 32'd0);
        @(posedge vga_clk); #1;
        rdn = 1'b1;
        @(negedge vga_clk);
        checkOutput("drain_we", 32'(ram_we), 32'd1);
        checkOutput("drain_addr", 32'(ram_addr), 32'd1);
        @(posedge vga_clk); #1;
        @(negedge vga_clk);
        checkOutput("fifth_ready", 32'(cpu_ready), 32'd1);
        @(posedge vga_clk); #1;
        cpu_valid = 1'b0;
        waitDrain("full_drain");
        bad = 0;
        for (int i = 1; i <= 5; i++) if (ram[i] !== 12'(i)) bad++;
        checkOutput("full_ram", 32'(bad), 32'd0);

        // One full line with a write offered every cycle.
        line_n    = 0;
        cpu_valid = 1'b1;
        cpu_addr  = AW'(2000);
        cpu_data  = 12'd0;
        for (int c = 0; c < 800; c++) begin
            row_addr = 9'd10;
            col_addr = 10'(c);
            rdn      = (c < 640) ? 1'b0 : 1'b1;
            @(negedge vga_clk);
            acc = cpu_ready;
            @(posedge vga_clk); #1;
            if (acc) begin
                line_n++;
                cpu_addr = AW'(2000 + line_n);
                cpu_data = 12'(line_n);
            end
        end
        cpu_valid = 1'b0;
        rdn       = 1'b1;
        waitDrain("line_drain");
        bad = 0;
        for (int k = 0; k < line_n; k++) if (ram[2000 + k] !== 12'(k)) bad++;
        checkOutput("line_ram", 32'(bad), 32'd0);
        checkOutput("line_min", 32'(line_n > 400), 32'd1);

        // Out-of-range address is swallowed and flagged; err_clr wins over a new error.
        pushWrite(AW'(76800), 12'hBAD);
        @(negedge vga_clk);
        checkOutput("oor_err", 32'(addr_err), 32'd1);
        checkOutput("oor_count", 32'(fifo_count), 32'd0);
        @(posedge vga_clk); #1;
        err_clr   = 1'b1;
        cpu_valid = 1'b1;
        cpu_addr  = AW'(100000);
        @(posedge vga_clk); #1;
        err_clr   = 1'b0;
        cpu_valid = 1'b0;
        @(negedge vga_clk);
        checkOutput("clr_prio", 32'(addr_err), 32'd0);
        checkOutput("clr_count", 32'(fifo_count), 32'd0);
        pushWrite(AW'(76799), 12'h777);
        @(negedge vga_clk);
        checkOutput("edge_err", 32'(addr_err), 32'd0);
        waitDrain("edge_drain");
        checkOutput("edge_ram", 32'(ram[76799]), 32'h777);

        // Reset while three writes are pending.
        applyStimulus(9'd0, 10'd0, 1'b0);
        cpu_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cpu_addr = AW'(i);
            cpu_data = 12'hEEE;
            @(posedge vga_clk); #1;
        end
        cpu_valid = 1'b0;
        @(negedge vga_clk);
        checkOutput("mid_count", 32'(fifo_count), 32'd3);
        @(posedge vga_clk); #1;
        rdn = 1'b1;
        #1;
        checkOutput("mid_we", 32'(ram_we), 32'd1);
        clrn = 1'b0;
        #1;
        checkOutput("mid_rst_we", 32'(ram_we), 32'd0);
        checkOutput("mid_rst_count", 32'(fifo_count), 32'd0);
        checkOutput("mid_rst_ready", 32'(cpu_ready), 32'd0);
        @(posedge vga_clk); #1;
        clrn = 1'b1;
        repeat (4) @(posedge vga_clk);
        @(negedge vga_clk);
        bad = 0;
        for (int i = 1; i <= 3; i++) if (ram[i] !== 12'(i)) bad++;
        checkOutput("mid_ram", 32'(bad), 32'd0);
        checkOutput("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
